// File: rtl/pin_entry_buffer.sv
// Keypad PIN accumulator for the electronic lock: digit/backspace/confirm,
// inactivity timeout, valid/ready PIN offer and six-digit display packet.
package pin_entry_buffer_pkg;
  typedef logic [5:0][3:0] bcdPac_t;
endpackage

module pin_entry_buffer
  import pin_entry_buffer_pkg::*;
#(
  parameter int MAX_DIGITS     = 12,
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int MASK           = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_key_valid,
  input  logic [3:0]              i_key_code,
  output logic [4*MAX_DIGITS-1:0] o_pin_digits,
  output logic [3:0]              o_pin_len,
  output logic                    o_pin_valid,
  input  logic                    i_pin_ready,
  output logic                    o_err,
  output logic                    o_timeout,
  output bcdPac_t                 o_bcd_packet,
  output logic                    o_enable_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] CMAX = 4'(MAX_DIGITS);
  localparam logic [3:0] CMIN = 4'(MIN_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OFFER
  } state_t;

  typedef logic [MAX_DIGITS-1:0][3:0] buf_t;

  state_t         r_state;
  buf_t           r_buf;
  logic [3:0]     r_cnt;
  logic [TW-1:0]  r_timer;
  logic           r_err;
  logic           r_timeout;
  bcdPac_t        r_bcd;
  logic           r_en;

  state_t         w_state_nxt;
  buf_t           w_buf_nxt;
  logic [3:0]     w_cnt_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic           w_err_nxt;
  logic           w_timeout_nxt;
  bcdPac_t        w_bcd_nxt;
  logic           w_is_digit;
  logic           w_is_bs;
  logic           w_is_cf;
  logic           w_key;

  assign w_is_digit = (i_key_code <= 4'd9);
  assign w_is_bs    = (i_key_code == 4'hA);
  assign w_is_cf    = (i_key_code == 4'hB);
  assign w_key      = i_key_valid && i_en
                   && (r_state != S_OFFER)
                   && (w_is_digit || w_is_bs || w_is_cf);

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_cnt_nxt     = r_cnt;
    w_timer_nxt   = r_timer;
    w_err_nxt     = 1'b0;
    w_timeout_nxt = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_buf_nxt   = '1;
      w_cnt_nxt   = '0;
      w_timer_nxt = '0;
    end else if (r_state == S_OFFER) begin
      if (i_pin_ready) begin
        w_state_nxt = S_IDLE;
        w_buf_nxt   = '1;
        w_cnt_nxt   = '0;
      end
    end else if (w_key) begin
      w_timer_nxt = '0;
      unique case (1'b1)
        w_is_digit: begin
          if (r_cnt < CMAX) begin
            w_buf_nxt[r_cnt] = i_key_code;
            w_cnt_nxt        = r_cnt + 4'd1;
            w_state_nxt      = S_ENTRY;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        w_is_bs: begin
          if (r_cnt != 4'd0) begin
            w_buf_nxt[r_cnt - 4'd1] = 4'hF;
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
          end
        end
        w_is_cf: begin
          if (r_cnt >= CMIN) begin
            w_state_nxt = S_OFFER;
          end else begin
            w_err_nxt   = 1'b1;
            w_buf_nxt   = '1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end else if (r_state == S_ENTRY) begin
      // a key on the expiry cycle is handled above and wins
      if (r_timer == TMAX) begin
        w_state_nxt   = S_IDLE;
        w_buf_nxt     = '1;
        w_cnt_nxt     = '0;
        w_timer_nxt   = '0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end
  end

  // newest digit sits in BCD0; older ones shift left
  always_comb begin
    w_bcd_nxt = {6{4'hF}};
    if (i_en) begin
      if (w_state_nxt == S_IDLE) begin
        w_bcd_nxt = {6{4'hA}};
      end else begin
        for (int k = 0; k < 6; k++) begin
          if (4'(k) < w_cnt_nxt) begin
            if (MASK != 0 && k != 0)
              w_bcd_nxt[k] = 4'hA;
            else
              w_bcd_nxt[k] =
                w_buf_nxt[w_cnt_nxt - 4'(k) - 4'd1];
          end else begin
            w_bcd_nxt[k] = 4'hB;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_buf     <= '1;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_bcd     <= {6{4'hF}};
      r_en      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timer   <= w_timer_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
      r_bcd     <= w_bcd_nxt;
      r_en      <= i_en;
    end
  end

  assign o_pin_digits = r_buf;
  assign o_pin_len    = r_cnt;
  assign o_pin_valid  = (r_state == S_OFFER);
  assign o_err        = r_err;
  assign o_timeout    = r_timeout;
  assign o_bcd_packet = r_bcd;
  assign o_enable_o   = r_en;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Randomised and directed bench for pin_entry_buffer against a
// queue-based model of the PIN entry rules.
`timescale 1ns/1ps
module tb_pin_entry_buffer;
  import pin_entry_buffer_pkg::*;

  localparam int MAXD = 12;
  localparam int MIND = 4;
  localparam int TO   = 20;
  localparam int MSK  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        kv = 1'b0;
  logic [3:0]  kc = 4'd0;
  logic        ready = 1'b0;
  logic [47:0] pin_digits;
  logic [3:0]  pin_len;
  logic        pin_valid;
  logic        err;
  logic        tmo;
  bcdPac_t     bcd;
  logic        en_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pin_entry_buffer #(
    .MAX_DIGITS(MAXD),
    .MIN_DIGITS(MIND),
    .TIMEOUT_CYCLES(TO),
    .MASK(MSK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_en(en),
    .i_key_valid(kv),
    .i_key_code(kc),
    .o_pin_digits(pin_digits),
    .o_pin_len(pin_len),
    .o_pin_valid(pin_valid),
    .i_pin_ready(ready),
    .o_err(err),
    .o_timeout(tmo),
    .o_bcd_packet(bcd),
    .o_enable_o(en_o)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  // model: entered digits in order, offer flag, idle-cycle count
  int q[$];
  bit m_offer = 1'b0;
  int m_idle = 0;
  bit m_err = 1'b0;
  bit m_to = 1'b0;
  bit m_en = 1'b0;

  function automatic logic [47:0] exp_digits();
    logic [47:0] r;
    for (int i = 0; i < MAXD; i++)
      r[i*4 +: 4] = (i < q.size()) ? 4'(q[i]) : 4'hF;
    return r;
  endfunction

  function automatic logic [23:0] exp_bcd();
    logic [23:0] r;
    int n;
    n = q.size();
    r = 24'hFFFFFF;
    if (m_en) begin
      if (!m_offer && n == 0) begin
        r = 24'hAAAAAA;
      end else begin
        for (int k = 0; k < 6; k++) begin
          if (k >= n)               r[k*4 +: 4] = 4'hB;
          else if (MSK != 0 && k > 0) r[k*4 +: 4] = 4'hA;
          else                      r[k*4 +: 4] = 4'(q[n-1-k]);
        end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    m_err = 1'b0;
    m_to  = 1'b0;
    m_en  = en;
    if (!en) begin
      q.delete();
      m_offer = 1'b0;
      m_idle = 0;
    end else if (m_offer) begin
      if (ready) begin
        q.delete();
        m_offer = 1'b0;
      end
    end else if (kv && kc <= 4'hB) begin
      m_idle = 0;
      if (kc <= 4'd9) begin
        if (q.size() < MAXD) q.push_back(int'(kc));
        else m_err = 1'b1;
      end else if (kc == 4'hA) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (q.size() >= MIND) begin
        m_offer = 1'b1;
      end else begin
        m_err = 1'b1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        q.delete();
        m_to = 1'b1;
        m_idle = 0;
      end
    end
  endtask

  // inputs change at negedge+1, so at negedge they still hold the
  // values sampled by the preceding posedge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_offer = 1'b0;
      m_idle = 0;
      m_err = 1'b0;
      m_to = 1'b0;
      m_en = 1'b0;
    end else begin
      model_step();
    end
    if (chk_on) begin
      chk("pin_digits", 64'(pin_digits), 64'(exp_digits()));
      chk("pin_len", 64'(pin_len), 64'(q.size()));
      chk("pin_valid", 64'(pin_valid), 64'(m_offer));
      chk("err", 64'(err), 64'(m_err));
      chk("timeout", 64'(tmo), 64'(m_to));
      chk("enable_o", 64'(en_o), 64'(m_en));
      chk("bcd_packet", 64'(bcd), 64'(exp_bcd()));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    kv = 1'b1;
    kc = c;
    tick();
    kv = 1'b0;
  endtask

  int found;
  bit saw;
  logic [3:0] len_at;

  task automatic wait_timeout(input int lim);
    found = -1;
    len_at = 4'hx;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (tmo && found < 0) begin
        found = i;
        len_at = pin_len;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    #2 chk("reset_bcd", 64'(bcd), 64'hFFFFFF);
    chk("reset_len", 64'(pin_len), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_on = 1'b1;

    en = 1'b1;
    tick();
    chk("en_rise_enable", 64'(en_o), 64'd1);
    chk("en_rise_dash", 64'(bcd), 64'hAAAAAA);

    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk("mask_1234", 64'(bcd), 64'hBBAAA4);
    press(4'hB);
    chk("offer_valid", 64'(pin_valid), 64'd1);
    chk("offer_len", 64'(pin_len), 64'd4);
    chk("offer_digits", 64'(pin_digits), 64'hFFFFFFFF4321);
    repeat (5) tick();
    chk("offer_held", 64'(pin_valid), 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("xfer_valid", 64'(pin_valid), 64'd0);
    chk("xfer_dash", 64'(bcd), 64'hAAAAAA);

    press(4'd1);
    press(4'd2);
    press(4'hA);
    chk("bs_len1", 64'(pin_len), 64'd1);
    press(4'd9);
    press(4'hA);
    press(4'hA);
    chk("bs_len0", 64'(pin_len), 64'd0);
    press(4'hA);
    chk("bs_empty_err", 64'(err), 64'd0);
    chk("bs_empty_dash", 64'(bcd), 64'hAAAAAA);

    for (int i = 0; i < 12; i++) press(4'(i % 10));
    press(4'd7);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_len", 64'(pin_len), 64'd12);
    press(4'hB);
    chk("ovf_offer_len", 64'(pin_len), 64'd12);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    press(4'd5);
    press(4'd6);
    press(4'd7);
    press(4'hB);
    chk("short_err", 64'(err), 64'd1);
    chk("short_len", 64'(pin_len), 64'd0);

    press(4'd1);
    press(4'd2);
    wait_timeout(40);
    chk("to_cycle", 64'(found), 64'd20);
    chk("to_len", 64'(len_at), 64'd0);

    press(4'd1);
    press(4'd2);
    saw = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (tmo) saw = 1'b1;
    end
    press(4'd3);
    if (tmo) saw = 1'b1;
    chk("to_key19_none", 64'(saw), 64'd0);
    wait_timeout(40);
    chk("to_restart", 64'(found), 64'd20);

    press(4'd8);
    press(4'd8);
    press(4'd8);
    press(4'd8);
    press(4'hB);
    en = 1'b0;
    tick();
    chk("endrop_valid", 64'(pin_valid), 64'd0);
    chk("endrop_digits", 64'(pin_digits), 64'hFFFFFFFFFFFF);
    chk("endrop_bcd", 64'(bcd), 64'hFFFFFF);
    en = 1'b1;
    tick();

    press(4'd5);
    press(4'd6);
    #3 rst = 1'b1;
    #1 chk("rst_async_len", 64'(pin_len), 64'd0);
    chk("rst_async_digits", 64'(pin_digits), 64'hFFFFFFFFFFFF);
    chk("rst_async_en", 64'(en_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    begin
      int quiet;
      int r;
      quiet = 0;
      repeat (4000) begin
        en = ($urandom_range(0, 99) != 0);
        ready = ($urandom_range(0, 3) == 0);
        if (quiet == 0 && $urandom_range(0, 149) == 0)
          quiet = $urandom_range(15, 30);
        if (quiet > 0) begin
          quiet--;
          kv = 1'b0;
        end else begin
          kv = ($urandom_range(0, 2) == 0);
        end
        r = $urandom_range(0, 19);
        if (r < 12)      kc = 4'(r % 10);
        else if (r < 15) kc = 4'hA;
        else if (r < 17) kc = 4'hB;
        else             kc = 4'($urandom_range(12, 15));
        tick();
      end
    end
    kv = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_entry_buffer.md
Name: pin_entry_buffer

Overview:
Operational-mode keypad accumulator for the electronic lock. It collects decoded key presses into a PIN buffer and handles backspace, confirm and inactivity timeout. It offers the completed PIN to the lock controller over a valid/ready handshake. It also produces the six-digit BCD packet and enable that feed the display stage's operational inputs (bcd_packet_operacional / enable_o).

Parameters:
MAX_DIGITS, 12, maximum PIN length (4..15)
MIN_DIGITS, 4, minimum length accepted on confirm
TIMEOUT_CYCLES, 5000, idle clock cycles in ENTRY before the buffer is discarded
MASK, 1, 1 = only the newest digit is shown in clear and older displayed digits show as dash

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  operational mode active
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 4'hA = '*' backspace; 4'hB = '#' confirm; others ignored
pin_digits  out  4*MAX_DIGITS  entered PIN; nibble i = i-th digit entered; unused nibbles 4'hF
pin_len  out  4  number of digits in pin_digits
pin_valid  out  1  PIN offered to controller
pin_ready  in  1  controller accepts PIN
err  out  1  one-cycle pulse: overflow digit, or confirm with too few digits
timeout  out  1  one-cycle pulse: buffer discarded by inactivity
bcd_packet  out  bcdPac_t  BCD0..BCD5 to display; BCD0 = rightmost digit
enable_o  out  1  display enable, registered copy of en

Behaviour:
- Reset (async): state IDLE, count 0, buffer nibbles 4'hF, pin_valid/err/timeout 0, pin_len 0, all bcd_packet nibbles 4'hF, enable_o 0, timer 0.
- States: IDLE (count=0), ENTRY (count>=1), OFFER (pin_valid=1).
- Keys are accepted only when en=1 and state != OFFER. Otherwise key_valid is ignored.
- Digit key:
  - count<MAX_DIGITS: store at nibble[count], count+1, go to ENTRY.
  - count==MAX_DIGITS: digit dropped, err pulse, buffer unchanged.
- '*' backspace:
  - count>0: nibble[count-1] <= 4'hF, count-1; go to IDLE if count becomes 0.
  - count==0: no effect, no err.
- '#' confirm:
  - count>=MIN_DIGITS: go to OFFER; pin_valid=1 and pin_len=count from the next cycle.
  - Otherwise: err pulse, buffer cleared, go to IDLE.
- OFFER:
  - pin_digits, pin_len and bcd_packet are held stable.
  - Transfer happens on the clock edge where pin_valid && pin_ready. On the next cycle pin_valid=0, buffer cleared, state IDLE.
  - No timeout applies in OFFER.
- Timer:
  - Counts only in ENTRY and clears to 0 on every accepted key.
  - When it reaches TIMEOUT_CYCLES-1 with no key that cycle: clear buffer, go to IDLE, timeout pulse.
  - If a key and expiry coincide, the key wins and the timer restarts.
- en low, any state including OFFER: next cycle buffer cleared, pin_valid=0, go to IDLE, timer 0. No err or timeout pulse.
- Display packet (registered, updates 1 cycle after the accepted key or state change; enable_o aligned with it):
  - IDLE with en=1: all six nibbles 4'hA (dash prompt).
  - ENTRY/OFFER, for k=0..5:
    - k<min(count,6): BCD_k = digit[count-1-k].
    - k>=count: 4'hB (blank).
    - MASK=1: positions 1..min(count,6)-1 forced to 4'hA.
  - count>6: the newest six digits are shown and older digits are not displayed.
  - en=0: nibbles 4'hF.
- err and timeout are registered single-cycle pulses, asserted the cycle after the cause.

Test Plan:
- Reset, then en=1 -> cycle after en rises enable_o=1 and BCD0..5=A,A,A,A,A,A; pin_valid=0.
- Keys 1,2,3,4 then '#', pin_ready=0 for 5 cycles then 1 -> pin_len=4; pin_digits[15:0]=16'h4321 and upper nibbles F; pin_valid held until the ready edge, then 0; display returns to dashes. With MASK=1, display during entry after "1234" is BCD0=4, BCD1..3=A, BCD4..5=B.
- Key sequence 1,2,'*',9,'*','*','*' -> count 1, then 0, then stays 0 with no err; state IDLE, display all A.
- 12 digits then a 13th digit -> err pulse, pin_len stays 12 on confirm. Confirm after 3 digits -> err pulse, buffer cleared.
- 2 digits then no key for TIMEOUT_CYCLES (override to 20) -> timeout pulse at cycle 20, count 0. A key arriving on cycle 19 -> no timeout, timer restarts.
- Drop en while in OFFER, and separately assert rst mid-entry -> pin_valid 0, buffer all F, IDLE. rst asserts outputs immediately, without waiting for a clock edge.
